host_bus_arb: RTL
=================

Name: host_bus_arb

Overview:
- Two-requester arbiter and sequencer for the shared 16-bit host register bus that feeds host_ctrl and the other register-mapped slaves.
- Requester 0 is the external host bridge; requester 1 is an internal configuration sequencer, e.g. the PWM setup engine.
- Grants the bus round-robin and runs one complete register access per grant (cs, rd_en/wr_en, address, write data).
- Captures read data and returns a one-cycle ack to the granted requester.

Parameters:
- ACC_CYC, 1, number of cycles host_cs is held per access. Legal range 1..15; it sets the slave read settle time.

Ports:
- host_clk  in  1  clock
- host_rst_l  in  1  asynchronous active-low reset
- m0_req  in  1  requester 0 access request; level, held until ack
- m0_wr  in  1  1 = write, 0 = read
- m0_addr  in  16  register address
- m0_wdata  in  16  write data
- m0_ack  out  1  one-cycle completion pulse
- m0_rdata  out  16  read data; valid while m0_ack is high
- m1_req, m1_wr, m1_addr, m1_wdata, m1_ack, m1_rdata  same as m0_*, for requester 1
- host_addr  out  16  slave bus address
- host_wr_data  out  16  slave bus write data
- host_cs  out  1  slave bus chip select
- host_rd_en  out  1  slave bus read strobe
- host_wr_en  out  1  slave bus write strobe
- host_rd_data  in  16  slave bus read data; combinational from the slave, valid while host_rd_en is high
- busy  out  1  high in ACC and ACK states
- grant  out  1  index of the current or last granted requester

Behaviour:
- Reset: host_rst_l is asynchronous, active-low. All outputs go to 0, state = IDLE, last_grant = 1 so requester 0 wins the first tie.
- A reset asserted mid-access aborts immediately; no ack is issued afterwards.
- All outputs are registered. State machine: IDLE, ACC, ACK.
- IDLE:
  - If exactly one req is high at a clock edge, grant that requester.
  - If both are high, grant the one that is not last_grant; last_grant <= granted index.
  - On grant, latch addr, wdata and wr from the winner and go to ACC. Cycle counter = ACC_CYC-1.
  - If no req is high, stay in IDLE.
- ACC, ACC_CYC cycles:
  - host_cs = 1; host_addr and host_wr_data = latched values.
  - Read: host_rd_en = 1 for all ACC cycles.
  - Write: host_wr_en = 1 in the first ACC cycle only, so the slave sees exactly one write per grant.
  - On the edge that ends the last ACC cycle: capture host_rd_data into the granted requester's rdata (reads), or 0 (writes). Go to ACK.
- ACK, 1 cycle:
  - host_cs, host_rd_en and host_wr_en = 0; host_addr and host_wr_data = 0.
  - mX_ack = 1 for the granted requester only.
  - Requests are not sampled in ACK. Go to IDLE.
- Latency: ack asserts exactly ACC_CYC+1 cycles after the IDLE edge that sampled req. Bus throughput is one access per ACC_CYC+2 cycles.
- Requester rules:
  - Hold req, wr, addr and wdata stable until ack.
  - Deassert req at the edge that ends the ack cycle. A req still high in the following IDLE cycle is a new request.
  - A req dropped before grant is simply not served.
  - Changing addr/wdata after grant has no effect, because the values are latched.
- mX_rdata holds its last captured value until that requester's next completed read or write.
- Back-to-back: a requester re-asserting in the IDLE cycle after its own ack loses to a waiting other requester, per round-robin.
- In IDLE, busy = 0.

Test Plan:
- m0 read addr 0x0001, slave returns 0x0DB1, ACC_CYC=1 -> cs/rd_en high for 1 cycle with host_addr=0x0001; m0_ack high 2 cycles after the req edge with m0_rdata=0x0DB1; m1_ack stays 0.
- m1 write addr 0x0000 data 0x1234 -> host_wr_en high exactly 1 cycle with host_wr_data=0x1234; m1_ack next cycle; m1_rdata=0.
- m0 and m1 both request reads continuously from reset -> grant order m0, m1, m0, m1; each ack after 2 cycles; gap of ACC_CYC+2 = 3 cycles between access starts.
- ACC_CYC=3, m0 read while slave data changes 0xAAAA->0x5555 in the 2nd ACC cycle -> rd_en high 3 cycles; m0_rdata=0x5555 (value at the last ACC edge); ack 4 cycles after the req edge.
- Reset asserted during the 2nd ACC cycle of an m1 write (ACC_CYC=3) -> all outputs 0 immediately; no m1_ack; after release, a simultaneous m0/m1 request grants m0 first.
- m1 re-asserts req in the IDLE cycle right after its ack while m0 is waiting -> m0 granted next, then m1.

Source files
------------

// File: rtl/host_bus_arb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// host_bus_arb : two-requester round-robin arbiter and access sequencer for
//                the shared 16-bit host register bus.
// Revision     : 1.0
// ============================================================================
module host_bus_arb #(
    parameter int ACC_CYC = 1
) (
    input  logic        host_clk,
    input  logic        host_rst_l,
    input  logic        m0_req,
    input  logic        m0_wr,
    input  logic [15:0] m0_addr,
    input  logic [15:0] m0_wdata,
    output logic        m0_ack,
    output logic [15:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_wr,
    input  logic [15:0] m1_addr,
    input  logic [15:0] m1_wdata,
    output logic        m1_ack,
    output logic [15:0] m1_rdata,
    output logic [15:0] host_addr,
    output logic [15:0] host_wr_data,
    output logic        host_cs,
    output logic        host_rd_en,
    output logic        host_wr_en,
    input  logic [15:0] host_rd_data,
    output logic        busy,
    output logic        grant
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        ACK  = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(ACC_CYC - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        last_grant_q, last_grant_d;
    logic        grant_q, grant_d;
    logic        busy_q, busy_d;
    logic [15:0] host_addr_q, host_addr_d;
    logic [15:0] host_wr_data_q, host_wr_data_d;
    logic        host_cs_q, host_cs_d;
    logic        host_rd_en_q, host_rd_en_d;
    logic        host_wr_en_q, host_wr_en_d;
    logic        m0_ack_q, m0_ack_d;
    logic        m1_ack_q, m1_ack_d;
    logic [15:0] m0_rdata_q, m0_rdata_d;
    logic [15:0] m1_rdata_q, m1_rdata_d;

    logic        win;
    logic        win_wr;
    logic [15:0] cap_data;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        last_grant_d   = last_grant_q;
        grant_d        = grant_q;
        busy_d         = busy_q;
        host_addr_d    = host_addr_q;
        host_wr_data_d = host_wr_data_q;
        host_cs_d      = host_cs_q;
        host_rd_en_d   = host_rd_en_q;
        host_wr_en_d   = host_wr_en_q;
        m0_ack_d       = 1'b0;
        m1_ack_d       = 1'b0;
        m0_rdata_d     = m0_rdata_q;
        m1_rdata_d     = m1_rdata_q;
        // On a tie the requester that did not win last time takes the bus
        win            = (m0_req && m1_req) ? ~last_grant_q : m1_req;
        win_wr         = win ? m1_wr : m0_wr;
        cap_data       = host_rd_en_q ? host_rd_data : 16'h0000;

        case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    state_d        = ACC;
                    cnt_d          = CNT_INIT;
                    grant_d        = win;
                    last_grant_d   = win;
                    busy_d         = 1'b1;
                    host_addr_d    = win ? m1_addr : m0_addr;
                    host_wr_data_d = win ? m1_wdata : m0_wdata;
                    host_cs_d      = 1'b1;
                    host_rd_en_d   = ~win_wr;
                    host_wr_en_d   = win_wr;
                end
            end
            ACC: begin
                // A single write strobe per grant, whatever the access length
                host_wr_en_d = 1'b0;
                if (cnt_q == 4'd0) begin
                    state_d        = ACK;
                    host_cs_d      = 1'b0;
                    host_rd_en_d   = 1'b0;
                    host_addr_d    = 16'h0000;
                    host_wr_data_d = 16'h0000;
                    if (grant_q) begin
                        m1_rdata_d = cap_data;
                        m1_ack_d   = 1'b1;
                    end else begin
                        m0_rdata_d = cap_data;
                        m0_ack_d   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ACK: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge host_clk or negedge host_rst_l) begin
        if (!host_rst_l) begin
            state_q        <= IDLE;
            cnt_q          <= 4'd0;
            last_grant_q   <= 1'b1;
            grant_q        <= 1'b0;
            busy_q         <= 1'b0;
            host_addr_q    <= 16'h0000;
            host_wr_data_q <= 16'h0000;
            host_cs_q      <= 1'b0;
            host_rd_en_q   <= 1'b0;
            host_wr_en_q   <= 1'b0;
            m0_ack_q       <= 1'b0;
            m1_ack_q       <= 1'b0;
            m0_rdata_q     <= 16'h0000;
            m1_rdata_q     <= 16'h0000;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            last_grant_q   <= last_grant_d;
            grant_q        <= grant_d;
            busy_q         <= busy_d;
            host_addr_q    <= host_addr_d;
            host_wr_data_q <= host_wr_data_d;
            host_cs_q      <= host_cs_d;
            host_rd_en_q   <= host_rd_en_d;
            host_wr_en_q   <= host_wr_en_d;
            m0_ack_q       <= m0_ack_d;
            m1_ack_q       <= m1_ack_d;
            m0_rdata_q     <= m0_rdata_d;
            m1_rdata_q     <= m1_rdata_d;
        end
    end

    assign m0_ack       = m0_ack_q;
    assign m1_ack       = m1_ack_q;
    assign m0_rdata     = m0_rdata_q;
    assign m1_rdata     = m1_rdata_q;
    assign host_addr    = host_addr_q;
    assign host_wr_data = host_wr_data_q;
    assign host_cs      = host_cs_q;
    assign host_rd_en   = host_rd_en_q;
    assign host_wr_en   = host_wr_en_q;
    assign busy         = busy_q;
    assign grant        = grant_q;

endmodule
`default_nettype wire
